regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single register-file write port between several writeback requesters (ALU, multiply/divide unit, load path) using round-robin arbitration. It turns each accepted request into a registered one-hot write enable plus write data for the register bank. The bank is built from negative-edge, enable-gated flip-flops and captures mid-cycle. The block also publishes the in-flight write for the bypass/forwarding logic.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback requesters; index 0 has top priority after reset
- NUM_REGS, 32, registers in the bank; register 0 is hardwired to zero
- ADDR_W, 5, register address width, with NUM_REGS <= 2**ADDR_W
- DATA_W, 32, register data width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- clr_n  in  1  asynchronous, active-low reset
- hold  in  1  freeze arbitration; no grants while high
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; requester i is at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing as req_addr
- req_ready  out  NUM_REQ  one-hot grant, combinational
- reg_we  out  NUM_REGS  registered one-hot write enable to the bank
- reg_wdata  out  DATA_W  registered write data to the bank
- wb_valid  out  1  registered; a write to a nonzero register is in flight this cycle
- wb_addr  out  ADDR_W  registered address of the in-flight write

## Operation
- Handshake:
  - A transfer occurs at a rising edge when req_valid[i] and req_ready[i] are both high.
  - The requester must hold valid, addr and data stable until that edge.
  - A requester must not drop valid before it is granted.
- Grant:
  - When hold=0 and clr_n=1, req_ready has exactly one bit set: the first valid requester at or after rr_ptr, searching upward and wrapping modulo NUM_REQ.
  - req_ready is all zero when no request is valid, hold=1, or clr_n=0.
- rr_ptr:
  - Width is ceil(log2(NUM_REQ)).
  - After a transfer from requester g, rr_ptr becomes (g+1) mod NUM_REQ.
  - rr_ptr is unchanged in cycles with no transfer.
- Output register, on a transfer with address a:
  - reg_wdata <= data.
  - reg_we <= one-hot(a) if a != 0 and a < NUM_REGS; otherwise all zero. The transfer still completes and the write is dropped silently.
  - wb_valid <= (reg_we nonzero).
  - wb_addr <= a.
- Cycles with no transfer: reg_we <= 0 and wb_valid <= 0. reg_wdata and wb_addr hold their previous values.
- Reset: asynchronous assertion of clr_n forces rr_ptr=0, reg_we=0, reg_wdata=0, wb_valid=0, wb_addr=0 immediately.

## Timing
- Request accepted at rising edge k:
  - reg_we and reg_wdata are valid from edge k until edge k+1.
  - The bank captures at the falling edge inside that cycle, so the register holds the new value from mid-cycle k+1 onward.
  - Latency is one cycle to the write strobe and 1.5 cycles to the stored value.
- Throughput: one write per cycle, back-to-back, with no bubble between grants to different or identical requesters.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,2,0,1,2,...; no requester waits more than NUM_REQ-1 cycles.
- hold:
  - hold=1 at edge k blocks any transfer at k; reg_we is zero in the following cycle.
  - A write accepted at edge k-1 still strobes, because it is already registered.
- Simultaneous requests to the same register: only the granted requester writes. The others stay pending and write later in grant order, so the last writer wins.
- Reset mid-operation:
  - clr_n falling between edge k and the falling edge kills an in-flight strobe before bank capture, and that write is lost.
  - A requester stays pending if its handshake had not completed.
- Reset release:
  - The first grant is possible at the first rising edge where clr_n is high and stable.
  - rr_ptr=0 then, so requester 0 wins ties.

## Test plan
- Reset: clr_n=0 with all req_valid=1 -> req_ready=000, reg_we=0, reg_wdata=0, wb_valid=0. Release clr_n -> requester 0 granted first.
- Single write: req 1 valid, addr=5, data=0xDEADBEEF -> req_ready=010. The next cycle has reg_we=1<<5, reg_wdata=0xDEADBEEF, wb_valid=1, wb_addr=5; reg_we is zero one cycle later.
- Round-robin: all three requesters valid for 6 cycles with distinct addresses 1/2/3 -> grant order 0,1,2,0,1,2 and reg_we sequence 1<<1, 1<<2, 1<<3 repeating with no idle cycles.
- Register 0 and out-of-range writes: addr=0 with data=0xFFFFFFFF -> handshake completes, reg_we=0, wb_valid=0, and rr_ptr still advances.
- hold: requester 2 valid and hold=1 for 3 cycles -> req_ready=000 and reg_we=0 throughout. Drop hold -> grant on the next edge and the strobe one cycle later.
- Async reset mid-write: pulse clr_n low for a quarter cycle right after an acceptance edge -> reg_we drops immediately, the bank register keeps its old value, and rr_ptr returns to 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register-file write port
// Registers the granted write as a one-hot bank strobe and publishes it for forwarding.
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REGS-1:0]       reg_we,
  output logic [DATA_W-1:0]         reg_wdata,
  output logic                      wb_valid,
  output logic [ADDR_W-1:0]         wb_addr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    ptr_next;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] we_next;
  int                  idx;

  // Scan from the farthest offset down so the requester closest to rr_ptr is the last to overwrite.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    idx       = 0;
    if (clr_n && !hold) begin
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
        idx = (int'(rr_ptr) + j) % NUM_REQ;
        if (req_valid[idx]) begin
          req_ready      = '0;
          req_ready[idx] = 1'b1;
          gnt_idx        = PTR_W'(idx);
        end
      end
    end
  end

  assign xfer     = |req_ready;
  assign sel_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign ptr_next = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Register 0 and addresses beyond the bank match no enable bit, so those writes vanish.
  always_comb begin
    we_next = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      we_next[r] = (sel_addr == ADDR_W'(r));
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rr_ptr    <= '0;
      reg_we    <= '0;
      reg_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
    end else if (xfer) begin
      rr_ptr    <= ptr_next;
      reg_we    <= we_next;
      reg_wdata <= sel_data;
      wb_valid  <= |we_next;
      wb_addr   <= sel_addr;
    end else begin
      reg_we    <= '0;
      wb_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
// A falling-edge bank model stands in for the register bank fed by reg_we/reg_wdata.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        clr_n;
  logic        hold;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic [31:0] reg_we;
  logic [31:0] reg_wdata;
  logic        wb_valid;
  logic [4:0]  wb_addr;

  logic        bank_init;
  logic [31:0] bank [32];
  int          n_cmp;
  int          n_fail;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (bank_init) bank[r] <= 32'h0;
      else if (r != 0 && reg_we[r]) bank[r] <= reg_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    hold = 1'b0;
    set_req(0, 5'd1, 32'h0000_0A01);
    set_req(1, 5'd2, 32'h0000_0A02);
    set_req(2, 5'd3, 32'h0000_0A03);
    req_valid = 3'b111;
    repeat (2) tick;
    n_cmp++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    n_cmp++; if (reg_we !== 32'h0) begin n_fail++; $display("FAIL reset_we: got %h want 0", reg_we); end
    n_cmp++; if (reg_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", reg_wdata); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    n_cmp++; if (wb_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wb_addr: got %0d want 0", wb_addr); end
    clr_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL release_first_grant: got %b want 001", req_ready); end
    tick;
    req_valid = 3'b000;
    n_cmp++; if (reg_we !== 32'h0000_0002) begin n_fail++; $display("FAIL release_we: got %h want 00000002", reg_we); end
    n_cmp++; if (wb_valid !== 1'b1 || wb_addr !== 5'd1) begin n_fail++; $display("FAIL release_wb: got %b/%0d want 1/1", wb_valid, wb_addr); end
    tick;
    n_cmp++; if (reg_we !== 32'h0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL release_idle: got %h/%b want 0/0", reg_we, wb_valid); end
  endtask

  // rr_ptr = 1 on entry
  task automatic test_single_write;
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b want 010", req_ready); end
    tick;
    req_valid = 3'b000;
    n_cmp++; if (reg_we !== 32'h0000_0020) begin n_fail++; $display("FAIL single_we: got %h want 00000020", reg_we); end
    n_cmp++; if (reg_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_wdata: got %h want deadbeef", reg_wdata); end
    n_cmp++; if (wb_valid !== 1'b1 || wb_addr !== 5'd5) begin n_fail++; $display("FAIL single_wb: got %b/%0d want 1/5", wb_valid, wb_addr); end
    tick;
    n_cmp++; if (reg_we !== 32'h0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_after: got %h/%b want 0/0", reg_we, wb_valid); end
    n_cmp++; if (reg_wdata !== 32'hDEAD_BEEF || wb_addr !== 5'd5) begin n_fail++; $display("FAIL single_hold_vals: got %h/%0d want deadbeef/5", reg_wdata, wb_addr); end
    n_cmp++; if (bank[5] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_bank: got %h want deadbeef", bank[5]); end
  endtask

  task automatic test_round_robin;
    logic [2:0]  exp_gnt [6];
    logic [31:0] exp_we  [6];
    logic [31:0] exp_dat [6];
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_we  = '{32'h2, 32'h4, 32'h8, 32'h2, 32'h4, 32'h8};
    exp_dat = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
    clr_n = 1'b0;
    #1;
    clr_n = 1'b1;
    set_req(0, 5'd1, 32'h1111_0000);
    set_req(1, 5'd2, 32'h2222_0000);
    set_req(2, 5'd3, 32'h3333_0000);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++; if (req_ready !== exp_gnt[c]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, exp_gnt[c]); end
      tick;
      n_cmp++; if (reg_we !== exp_we[c] || reg_wdata !== exp_dat[c] || wb_valid !== 1'b1) begin
        n_fail++; $display("FAIL rr_write[%0d]: got %h/%h/%b want %h/%h/1", c, reg_we, reg_wdata, wb_valid, exp_we[c], exp_dat[c]);
      end
    end
    req_valid = 3'b000;
    tick;
  endtask

  // rr_ptr = 0 on entry
  task automatic test_reg0;
    set_req(0, 5'd0, 32'hFFFF_FFFF);
    req_valid = 3'b001;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL reg0_ready: got %b want 001", req_ready); end
    tick;
    set_req(1, 5'd6, 32'h0000_0066);
    req_valid = 3'b011;
    n_cmp++; if (reg_we !== 32'h0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL reg0_dropped: got %h/%b want 0/0", reg_we, wb_valid); end
    n_cmp++; if (reg_wdata !== 32'hFFFF_FFFF || wb_addr !== 5'd0) begin n_fail++; $display("FAIL reg0_wdata: got %h/%0d want ffffffff/0", reg_wdata, wb_addr); end
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL reg0_ptr_adv: got %b want 010", req_ready); end
    tick;
    req_valid = 3'b000;
    n_cmp++; if (reg_we !== 32'h0000_0040) begin n_fail++; $display("FAIL reg0_next_we: got %h want 00000040", reg_we); end
    tick;
    n_cmp++; if (bank[0] !== 32'h0) begin n_fail++; $display("FAIL reg0_bank: got %h want 0", bank[0]); end
  endtask

  // rr_ptr = 2 on entry
  task automatic test_hold;
    set_req(1, 5'd9, 32'h0000_0099);
    req_valid = 3'b010;
    tick;
    hold = 1'b1;
    set_req(2, 5'd7, 32'h0000_0077);
    req_valid = 3'b100;
    n_cmp++; if (reg_we !== 32'h0000_0200) begin n_fail++; $display("FAIL hold_prior_strobe: got %h want 00000200", reg_we); end
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b want 000", c, req_ready); end
      tick;
      n_cmp++; if (reg_we !== 32'h0) begin n_fail++; $display("FAIL hold_we[%0d]: got %h want 0", c, reg_we); end
    end
    hold = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL hold_release_ready: got %b want 100", req_ready); end
    tick;
    req_valid = 3'b000;
    n_cmp++; if (reg_we !== 32'h0000_0080 || reg_wdata !== 32'h77) begin n_fail++; $display("FAIL hold_release_we: got %h/%h want 00000080/77", reg_we, reg_wdata); end
    tick;
  endtask

  // rr_ptr = 0 on entry
  task automatic test_async_reset;
    set_req(0, 5'd4, 32'h0000_1111);
    req_valid = 3'b001;
    tick;
    req_valid = 3'b000;
    tick;
    n_cmp++; if (bank[4] !== 32'h0000_1111) begin n_fail++; $display("FAIL arst_prewrite: got %h want 00001111", bank[4]); end
    set_req(1, 5'd4, 32'h0000_2222);
    req_valid = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    clr_n = 1'b0;
    #1;
    n_cmp++; if (reg_we !== 32'h0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL arst_kill: got %h/%b want 0/0", reg_we, wb_valid); end
    clr_n = 1'b1;
    tick;
    n_cmp++; if (bank[4] !== 32'h0000_1111) begin n_fail++; $display("FAIL arst_bank_kept: got %h want 00001111", bank[4]); end
    req_valid = 3'b111;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL arst_ptr_zero: got %b want 001", req_ready); end
    req_valid = 3'b000;
    tick;
  endtask

  // rr_ptr = 0 on entry
  task automatic test_back_to_back;
    set_req(0, 5'd10, 32'h0000_00AA);
    set_req(1, 5'd10, 32'h0000_00BB);
    req_valid = 3'b011;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL b2b_first: got %b want 001", req_ready); end
    tick;
    req_valid = 3'b010;
    #1;
    n_cmp++; if (reg_we !== 32'h0000_0400 || reg_wdata !== 32'hAA) begin n_fail++; $display("FAIL b2b_w0: got %h/%h want 00000400/aa", reg_we, reg_wdata); end
    n_cmp++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL b2b_second: got %b want 010", req_ready); end
    tick;
    req_valid = 3'b000;
    n_cmp++; if (reg_we !== 32'h0000_0400 || reg_wdata !== 32'hBB) begin n_fail++; $display("FAIL b2b_w1: got %h/%h want 00000400/bb", reg_we, reg_wdata); end
    tick;
    n_cmp++; if (bank[10] !== 32'hBB) begin n_fail++; $display("FAIL b2b_last_wins: got %h want bb", bank[10]); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    bank_init = 1'b1;
    clr_n = 1'b0;
    hold = 1'b0;
    req_valid = 3'b000;
    req_addr = '0;
    req_data = '0;
    repeat (2) tick;
    bank_init = 1'b0;
    test_reset;
    test_single_write;
    test_round_robin;
    test_reg0;
    test_hold;
    test_async_reset;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
